// File: rtl/d_sram_like_bridge.sv
// M-stage to data-side sram-like bus bridge: one bus transaction per load/store,
// stalling the pipeline until it completes and holding the returned read word.
//
// state | meaning
// IDLE  | no transaction; a valid unflushed M access starts one
// REQ   | data_req high, waiting for data_addr_ok
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | transaction finished; held here while pipe_stall keeps M frozen
module d_sram_like_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  mem_wr,
    input  logic [1:0]            mem_size,
    input  logic [3:0]            mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  flush,
    input  logic                  pipe_stall,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   start;
    logic   rd_capture;

    // The bus encodes byte lanes through size + address, so the enables are not forwarded.
    logic unused_wen;
    assign unused_wen = ^mem_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_wr    <= 1'b0;
            data_size  <= 2'b00;
            data_addr  <= '0;
            data_wdata <= '0;
            mem_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                data_wr    <= mem_wr;
                data_size  <= mem_size;
                data_addr  <= mem_addr;
                data_wdata <= mem_wdata;
            end
            if (rd_capture) begin
                mem_rdata <= data_rdata;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        data_req   = 1'b0;
        mem_stall  = 1'b0;
        start      = 1'b0;
        rd_capture = 1'b0;
        case (state)
            IDLE: begin
                if (mem_en && !flush) begin
                    start     = 1'b1;
                    mem_stall = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                data_req  = 1'b1;
                mem_stall = 1'b1;
                if (data_addr_ok) begin
                    state_nxt  = data_data_ok ? DONE : WAIT;
                    rd_capture = data_data_ok && !data_wr;
                end
            end
            WAIT: begin
                // flush is ignored here: the bus transaction cannot be cancelled
                mem_stall = 1'b1;
                if (data_data_ok) begin
                    state_nxt  = DONE;
                    rd_capture = !data_wr;
                end
            end
            DONE: begin
                if (!pipe_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Scoreboard bench for d_sram_like_bridge: directed transactions push expected bus
// requests and read words; a negedge monitor pops and compares them as the DUT presents them.
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_wr, flush, pipe_stall;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, mem_rdata;
    logic        mem_stall;

    always #5 clk = ~clk;

    d_sram_like_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush(flush), .pipe_stall(pipe_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_rd;
    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    logic        req_prev = 1'b0;
    logic        outstanding = 1'b0;
    logic        done_pend = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: bus handshakes and completion are compared against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
            done_pend   = 1'b0;
            req_prev    = 1'b0;
        end else begin
            if (data_req && !req_prev) req_cnt++;
            req_prev = data_req;
            if (done_pend) begin
                done_pend = 1'b0;
                if (rd_q.size() == 0) begin
                    check("rd_queue_empty", 64'd1, 64'd0);
                end else begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    check("mem_rdata_done", {32'd0, mem_rdata}, {32'd0, e});
                    check("stall_done", {63'd0, mem_stall}, 64'd0);
                end
            end
            if (data_req && data_addr_ok) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 64'd1, 64'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check("req_wr",    {63'd0, data_wr},    {63'd0, r.wr});
                    check("req_size",  {62'd0, data_size},  {62'd0, r.size});
                    check("req_addr",  {32'd0, data_addr},  {32'd0, r.addr});
                    check("req_wdata", {32'd0, data_wdata}, {32'd0, r.wdata});
                end
                outstanding = 1'b1;
            end
            if (outstanding && data_data_ok) begin
                outstanding = 1'b0;
                done_pend   = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One M-stage access. Leaves mem_en high after DONE->IDLE so a caller can chain
    // the next access into that IDLE cycle.
    task automatic txn(input logic wr, input logic [1:0] size, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int alat, input int dlat,
                       input int nstall, input logic flush_wait);
        int base;
        mem_en = 1'b1; mem_wr = wr; mem_size = size; mem_wen = wen;
        mem_addr = addr; mem_wdata = wdata;
        req_q.push_back('{wr: wr, size: size, addr: addr, wdata: wdata});
        if (!wr) exp_rd = rdata;
        rd_q.push_back(exp_rd);
        base = req_cnt;
        @(negedge clk);
        check("idle_stall", {63'd0, mem_stall}, 64'd1);
        check("idle_noreq", {63'd0, data_req}, 64'd0);
        tick();
        for (int i = 0; i < alat; i++) begin
            @(negedge clk);
            check("req_stall", {63'd0, mem_stall}, 64'd1);
            check("req_high", {63'd0, data_req}, 64'd1);
            tick();
        end
        data_addr_ok = 1'b1;
        data_data_ok = (dlat == 0);
        data_rdata   = (dlat == 0) ? rdata : 32'h5555_5555;
        @(negedge clk);
        check("req_stall", {63'd0, mem_stall}, 64'd1);
        check("req_high", {63'd0, data_req}, 64'd1);
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'hA5A5_A5A5;
        if (dlat > 0) begin
            if (flush_wait) flush = 1'b1;
            for (int i = 0; i < dlat; i++) begin
                if (i == dlat - 1) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rdata;
                end
                @(negedge clk);
                check("wait_stall", {63'd0, mem_stall}, 64'd1);
                check("wait_noreq", {63'd0, data_req}, 64'd0);
                tick();
            end
            data_data_ok = 1'b0;
            data_rdata   = 32'h0BAD_F00D;
            flush        = 1'b0;
        end
        pipe_stall = (nstall > 0);
        for (int i = 0; i < nstall; i++) begin
            @(negedge clk);
            check("hold_stall", {63'd0, mem_stall}, 64'd0);
            check("hold_noreq", {63'd0, data_req}, 64'd0);
            check("hold_rdata", {32'd0, mem_rdata}, {32'd0, exp_rd});
            tick();
        end
        pipe_stall = 1'b0;
        @(negedge clk);
        check("done_stall", {63'd0, mem_stall}, 64'd0);
        tick();
        check("one_req", 64'(req_cnt - base), 64'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'b00; mem_wen = 4'h0;
        mem_addr = '0; mem_wdata = '0; flush = 1'b0; pipe_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        exp_rd = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req",   {63'd0, data_req},  64'd0);
        check("rst_rdata", {32'd0, mem_rdata}, 64'd0);
        check("rst_stall", {63'd0, mem_stall}, 64'd0);
        check("rst_addr",  {32'd0, data_addr}, 64'd0);
        tick();

        // 1: load word, addr_ok one cycle late, data_ok two cycles after addr_ok
        txn(1'b0, 2'b10, 4'hF, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1, 2, 0, 1'b0);
        mem_en = 1'b0;
        tick();
        // 2: store byte, addr_ok and data_ok together; mem_rdata keeps the load value
        txn(1'b1, 2'b00, 4'b1000, 32'h0000_2003, 32'hAB00_0000, 32'h1234_5678, 0, 0, 0, 1'b0);
        mem_en = 1'b0;
        tick();
        // 3: halfword load completing under a 4-cycle pipe_stall
        txn(1'b0, 2'b01, 4'b0011, 32'h0000_4002, 32'h0, 32'h1357_2468, 1, 1, 4, 1'b0);
        mem_en = 1'b0;
        tick();

        // 4a: flushed access in IDLE never issues
        begin
            int base;
            base = req_cnt;
            mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0000_7000; flush = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("flush_stall", {63'd0, mem_stall}, 64'd0);
                check("flush_noreq", {63'd0, data_req}, 64'd0);
                tick();
            end
            check("flush_req_cnt", 64'(req_cnt - base), 64'd0);
            mem_en = 1'b0; flush = 1'b0;
            tick();
        end
        // 4b: flush during WAIT does not cancel the transaction
        txn(1'b0, 2'b10, 4'hF, 32'h0000_5000, 32'h0, 32'h0F0F_F0F0, 0, 3, 0, 1'b1);
        mem_en = 1'b0;
        tick();

        // 5: reset while waiting for data_ok
        mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h0000_3000;
        req_q.push_back('{wr: 1'b0, size: 2'b10, addr: 32'h0000_3000, wdata: 32'h0});
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        @(negedge clk);
        check("wait_before_rst", {63'd0, mem_stall}, 64'd1);
        tick();
        rst = 1'b1; mem_en = 1'b0;
        tick();
        rst = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        check("rst_wait_req",   {63'd0, data_req},   64'd0);
        check("rst_wait_stall", {63'd0, mem_stall},  64'd0);
        check("rst_wait_addr",  {32'd0, data_addr},  64'd0);
        check("rst_wait_size",  {62'd0, data_size},  64'd0);
        check("rst_wait_rdata", {32'd0, mem_rdata},  64'd0);
        data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
        tick();
        data_data_ok = 1'b0;
        @(negedge clk);
        check("late_ok_rdata", {32'd0, mem_rdata}, 64'd0);
        check("late_ok_stall", {63'd0, mem_stall}, 64'd0);
        check("late_ok_req",   {63'd0, data_req},  64'd0);
        tick();

        // 6: back-to-back loads; the chained call checks IDLE at DONE+1 and REQ at DONE+2
        txn(1'b0, 2'b10, 4'hF, 32'h0000_6000, 32'h0, 32'h1111_2222, 0, 1, 0, 1'b0);
        txn(1'b0, 2'b10, 4'hF, 32'h0000_6004, 32'h0, 32'h3333_4444, 2, 0, 0, 1'b0);
        mem_en = 1'b0;
        repeat (2) tick();

        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("rd_q_drained",  64'(rd_q.size()),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
